mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive data grants made while inst_req is pending; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port inst_req, input, 1, fetch read request, held until acknowledged.
REQ-005 SHALL have port inst_addr, input, 32, fetch byte address.
REQ-006 SHALL have port inst_cancel, input, 1, fetch flush; discard any pending or in-flight fetch.
REQ-007 SHALL have port inst_ack, output, 1, fetch request accepted this cycle.
REQ-008 SHALL have port inst_done, output, 1, one-cycle pulse with inst_rdata valid.
REQ-009 SHALL have port inst_rdata, output, 32, fetch read data.
REQ-010 SHALL have port data_req, input, 1, load/store request, held until acknowledged.
REQ-011 SHALL have port data_addr, input, 32, load/store byte address.
REQ-012 SHALL have port data_wen, input, 4, byte write enables; 4'b0000 means read.
REQ-013 SHALL have port data_wdata, input, 32, store data.
REQ-014 SHALL have port data_ack, output, 1, data request accepted this cycle.
REQ-015 SHALL have port data_done, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port data_rdata, output, 32, load data, valid with data_done on reads.
REQ-017 SHALL have port mem_req, output, 1, memory request, held until mem_gnt.
REQ-018 SHALL have ports mem_addr (output, 32), mem_wen (output, 4) and mem_wdata (output, 32), the latched request fields.
REQ-019 SHALL have port mem_gnt, input, 1, memory accepted the request.
REQ-020 SHALL have port mem_rvalid, input, 1, read data valid.
REQ-021 SHALL have port mem_rdata, input, 32, read data.
REQ-022 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-023 SHALL implement the FSM states IDLE, ISSUE, WAIT_R and RESP, with at most one outstanding memory transaction.
REQ-024 SHALL arbitrate only in IDLE, asserting inst_ack or data_ack combinationally in the same cycle, latching the winner's addr, wen and wdata plus an owner flag, then going to ISSUE.
REQ-025 SHALL give data priority over inst, except that inst wins when both request and starve_cnt == STARVE_LIMIT.
REQ-026 SHALL maintain starve_cnt, 4 bits, incrementing (saturating at STARVE_LIMIT) on each data grant while inst_req=1, and clearing on each inst grant.
REQ-027 SHALL not accept an inst_req presented in IDLE with inst_cancel=1 in the same cycle, and SHALL then grant data if data_req=1.
REQ-028 SHALL, in ISSUE, drive mem_req=1 with stable latched fields; on mem_gnt go to RESP if mem_wen != 0, else to WAIT_R.
REQ-029 SHALL, in WAIT_R, capture mem_rdata into the owner's rdata register on mem_rvalid and go to RESP.
REQ-030 SHALL, in RESP, pulse the owner's done for exactly one cycle, then return to IDLE; read latency is one cycle after mem_rvalid, write latency one cycle after mem_gnt.
REQ-031 SHALL ignore mem_gnt outside ISSUE and mem_rvalid outside WAIT_R.
REQ-032 SHALL, on inst_cancel in ISSUE, WAIT_R or RESP with owner=inst, complete the memory transaction normally but suppress inst_done; inst_rdata may still update.
REQ-033 SHALL never deassert mem_req or alter the mem_* fields before mem_gnt.
REQ-034 SHALL ignore inst_cancel with respect to data transactions.
REQ-035 SHALL hold inst_rdata and data_rdata at their last captured value between transactions.

Reset
REQ-036 SHALL, while rst=1, go to IDLE next edge, drop any in-flight transaction, and clear starve_cnt, the owner and cancel flags, and both rdata registers to 0.
REQ-037 SHALL drive mem_req, inst_ack, data_ack, inst_done, data_done and busy to 0 while rst=1, including the cycle rst is asserted.
REQ-038 SHALL treat a late mem_rvalid from a transaction dropped by reset as ignored (REQ-031).

Verification
REQ-039 SHALL cover this scenario: inst_req, addr 0x00000010; mem_gnt 1 cycle later; mem_rvalid with 0x8C080004 2 cycles later -> inst_ack at T0, mem_req T1, inst_done with inst_rdata=0x8C080004 one cycle after rvalid.
REQ-040 SHALL cover this scenario: inst_req and data_req (wen=4'b1111, addr 0x100, wdata 0xDEADBEEF) in the same cycle -> data_ack, mem_wen=4'b1111, data_done one cycle after mem_gnt, inst_ack at the next IDLE.
REQ-041 SHALL cover this scenario: data_req held continuously with inst_req, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 inst grant, with starve_cnt back at 0.
REQ-042 SHALL cover this scenario: inst fetch in WAIT_R plus inst_cancel pulse -> mem_rvalid accepted, no inst_done, FSM in IDLE 2 cycles after rvalid.
REQ-043 SHALL cover this scenario: rst asserted in ISSUE with mem_gnt held low -> mem_req=0 that cycle, IDLE next, late mem_rvalid produces no done.
REQ-044 SHALL cover this scenario: mem_gnt stalled 5 cycles -> mem_req, mem_addr, mem_wen and mem_wdata constant across all 5 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master (instruction fetch / data load-store) arbiter in front of a
// single-outstanding memory port.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/addr/cancel          fetch request (read only) and flush
//   inst_ack/done/rdata           fetch accept, completion pulse, read data
//   data_req/addr/wen/wdata       load/store request (wen == 0 means read)
//   data_ack/done/rdata           load/store accept, completion pulse, load data
//   mem_req/addr/wen/wdata        memory request, held with stable fields until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata memory accept and read return
//   busy                          high whenever the FSM is not idle
//
// Data normally wins; after STARVE_LIMIT consecutive data grants made while a fetch was
// waiting, the fetch wins the next contended arbitration.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_ack,
    output logic        inst_done,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic        data_ack,
    output logic        data_done,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitR, StResp} state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic        owner_inst_q, owner_inst_d;
    logic        cancel_q, cancel_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic grant_inst, grant_data;

    // A fetch flushed in the same cycle is not eligible; data is then free to win.
    always_comb begin
        grant_inst = inst_req & ~inst_cancel & (~data_req | (starve_q == StarveMax));
        grant_data = data_req & ~grant_inst;
    end

    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        cancel_d     = cancel_q;
        starve_d     = starve_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ack     = 1'b0;
        data_ack     = 1'b0;
        inst_done    = 1'b0;
        data_done    = 1'b0;
        mem_req      = 1'b0;
        busy         = (state_q != StIdle);

        // Remember a flush of our own fetch anywhere after acceptance.
        if (state_q != StIdle && owner_inst_q && inst_cancel) begin
            cancel_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (grant_inst) begin
                    inst_ack     = 1'b1;
                    owner_inst_d = 1'b1;
                    cancel_d     = 1'b0;
                    addr_d       = inst_addr;
                    wen_d        = 4'b0000;
                    wdata_d      = 32'h0;
                    starve_d     = 4'd0;
                    state_d      = StIssue;
                end else if (grant_data) begin
                    data_ack     = 1'b1;
                    owner_inst_d = 1'b0;
                    cancel_d     = 1'b0;
                    addr_d       = data_addr;
                    wen_d        = data_wen;
                    wdata_d      = data_wdata;
                    if (inst_req && starve_q != StarveMax) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    state_d = (wen_q != 4'b0000) ? StResp : StWaitR;
                end
            end
            StWaitR: begin
                if (mem_rvalid) begin
                    if (owner_inst_q) begin
                        inst_rdata_d = mem_rdata;
                    end else begin
                        data_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                if (owner_inst_q) begin
                    inst_done = ~cancel_q & ~inst_cancel;
                end else begin
                    data_done = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Handshakes are suppressed during the reset cycle itself, not just after it.
        if (rst) begin
            inst_ack  = 1'b0;
            data_ack  = 1'b0;
            inst_done = 1'b0;
            data_done = 1'b0;
            mem_req   = 1'b0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_inst_q <= 1'b0;
            cancel_q     <= 1'b0;
            starve_q     <= 4'd0;
            addr_q       <= 32'h0;
            wen_q        <= 4'b0000;
            wdata_q      <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            cancel_q     <= cancel_d;
            starve_q     <= starve_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wen    = wen_q;
    assign mem_wdata  = wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model and a done-driven scoreboard.
module tb_mem_arbiter;

    localparam int Limit = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_cancel, data_req;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_wen;
    logic        inst_ack, inst_done, data_ack, data_done, mem_req, busy;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wen;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    // Memory pins come from the auto responder or from directed stimulus.
    logic        auto_mem, sb_en;
    logic        a_gnt, a_rvalid, m_gnt, m_rvalid;
    logic [31:0] a_rdata, m_rdata;
    assign mem_gnt    = auto_mem ? a_gnt    : m_gnt;
    assign mem_rvalid = auto_mem ? a_rvalid : m_rvalid;
    assign mem_rdata  = auto_mem ? a_rdata  : m_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_ack(inst_ack), .inst_done(inst_done), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_wen(data_wen),
        .data_wdata(data_wdata), .data_ack(data_ack), .data_done(data_done),
        .data_rdata(data_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        bit          inst;
        bit          wr;
        logic [31:0] rdata;
    } item_t;

    item_t       sb_q[$];
    bit          grants[$];    // 1 = inst grant, in grant order
    int          checks, errors;
    int          starve;       // consecutive data grants while a fetch waited
    bit          mdl_busy;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wen;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; inst_cancel = 1'b0;
        m_gnt = 1'b0; m_rvalid = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        starve = 0; mdl_busy = 1'b0; sb_q.delete(); grants.delete();
    endtask

    // Randomized traffic; 'both' keeps both masters requesting continuously.
    task automatic run_traffic(input int cycles, input bit both);
        bit go_i, go_d, free_next, exp_i, exp_d, drained;
        item_t it;
        go_i = 0; go_d = 0; free_next = 0; drained = 0;
        auto_mem = 1'b1; sb_en = 1'b1;
        for (int c = 0; c < cycles + 300; c++) begin
            cyc();
            if (go_i) inst_req = 1'b0;
            if (go_d) data_req = 1'b0;
            if (c < cycles) begin
                if (!inst_req && (both || $urandom_range(0, 2) == 0)) begin
                    inst_req  = 1'b1;
                    inst_addr = $urandom & 32'hFFFF_FFFC;
                end
                if (!data_req && (both || $urandom_range(0, 1) == 0)) begin
                    data_req   = 1'b1;
                    data_addr  = $urandom & 32'hFFFF_FFFC;
                    data_wdata = $urandom;
                    data_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
            end else if (!inst_req && !data_req && !mdl_busy && sb_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
            if (free_next) begin
                mdl_busy = 1'b0;
                free_next = 1'b0;
            end
            exp_i = !mdl_busy && inst_req && (!data_req || starve == Limit);
            exp_d = !mdl_busy && data_req && !exp_i;
            check("inst_ack", 32'(inst_ack), 32'(exp_i));
            check("data_ack", 32'(data_ack), 32'(exp_d));
            go_i = exp_i;
            go_d = exp_d;
            if (exp_i) begin
                it.inst = 1'b1; it.wr = 1'b0; it.rdata = mem_model(inst_addr);
                cur_addr = inst_addr; cur_wen = 4'h0; cur_wdata = 32'h0;
                sb_q.push_back(it); grants.push_back(1'b1);
                starve = 0; mdl_busy = 1'b1;
            end
            if (exp_d) begin
                it.inst = 1'b0; it.wr = (data_wen != 4'h0); it.rdata = mem_model(data_addr);
                cur_addr = data_addr; cur_wen = data_wen; cur_wdata = data_wdata;
                sb_q.push_back(it); grants.push_back(1'b0);
                if (inst_req && starve < Limit) starve++;
                mdl_busy = 1'b1;
            end
            if (inst_done || data_done) free_next = 1'b1;
        end
        check("traffic_drained", 32'(drained), 32'd1);
        sb_en = 1'b0;
        auto_mem = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; auto_mem = 1'b0; sb_en = 1'b0;
        a_gnt = 1'b0; a_rvalid = 1'b0; a_rdata = 32'h0; m_rdata = 32'h0;
        inst_addr = 32'h0; data_addr = 32'h0; data_wen = 4'h0; data_wdata = 32'h0;
        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; inst_cancel = 1'b0;
        m_gnt = 1'b0; m_rvalid = 1'b0;

        fork
            // Auto memory responder: random grant and read-return latency.
            forever begin
                logic [31:0] la;
                bit          lw;
                cyc();
                if (auto_mem && mem_req) begin
                    la = mem_addr;
                    lw = (mem_wen != 4'h0);
                    repeat ($urandom_range(0, 3)) cyc();
                    a_gnt = 1'b1;
                    cyc();
                    a_gnt = 1'b0;
                    if (!lw) begin
                        repeat ($urandom_range(0, 2)) cyc();
                        a_rvalid = 1'b1;
                        a_rdata  = mem_model(la);
                        cyc();
                        a_rvalid = 1'b0;
                    end
                end
            end
            // Monitor: request-field stability and completion scoreboard.
            forever begin
                item_t it;
                @(negedge clk);
                if (sb_en) begin
                    if (mem_req) begin
                        check("mem_addr", mem_addr, cur_addr);
                        check("mem_wen", 32'(mem_wen), 32'(cur_wen));
                        check("mem_wdata", mem_wdata, cur_wdata);
                    end
                    if (inst_done || data_done) begin
                        if (sb_q.size() == 0) begin
                            check("unexpected_done", 32'(inst_done | data_done), 32'd0);
                        end else begin
                            it = sb_q.pop_front();
                            check("done_owner_inst", 32'(inst_done), 32'(it.inst));
                            check("done_owner_data", 32'(data_done), 32'(!it.inst));
                            if (it.inst) check("inst_rdata", inst_rdata, it.rdata);
                            else if (!it.wr) check("data_rdata", data_rdata, it.rdata);
                        end
                    end
                end
            end
        join_none

        // Reset state, including the cycle reset is first seen.
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_acks", 32'({inst_ack, data_ack, inst_done, data_done}), 0);
        cyc();
        @(negedge clk);
        check("rst_inst_rdata", inst_rdata, 0);
        check("rst_data_rdata", data_rdata, 0);

        // Single fetch read.
        do_reset();
        inst_addr = 32'h10; inst_req = 1'b1;
        @(negedge clk);
        check("f_ack", 32'(inst_ack), 1);
        check("f_idle", 32'(busy), 0);
        cyc(); inst_req = 1'b0; m_gnt = 1'b1;
        @(negedge clk);
        check("f_mem_req", 32'(mem_req), 1);
        check("f_mem_addr", mem_addr, 32'h10);
        check("f_mem_wen", 32'(mem_wen), 0);
        cyc(); m_gnt = 1'b0;
        @(negedge clk);
        check("f_waitr", 32'({mem_req, busy}), 32'b01);
        cyc(); m_rvalid = 1'b1; m_rdata = 32'h8C08_0004;
        @(negedge clk);
        check("f_no_early_done", 32'(inst_done), 0);
        cyc(); m_rvalid = 1'b0;
        @(negedge clk);
        check("f_done", 32'(inst_done), 1);
        check("f_rdata", inst_rdata, 32'h8C08_0004);
        cyc();
        @(negedge clk);
        check("f_back_idle", 32'({busy, inst_done}), 0);
        check("f_rdata_hold", inst_rdata, 32'h8C08_0004);

        // Simultaneous store and fetch: store first, fetch at next idle.
        do_reset();
        inst_addr = 32'h20; inst_req = 1'b1;
        data_addr = 32'h100; data_wen = 4'hF; data_wdata = 32'hDEAD_BEEF; data_req = 1'b1;
        @(negedge clk);
        check("c_data_ack", 32'({inst_ack, data_ack}), 32'b01);
        cyc(); data_req = 1'b0;
        @(negedge clk);
        check("c_mem_wen", 32'(mem_wen), 32'hF);
        check("c_mem_addr", mem_addr, 32'h100);
        check("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("c_no_inst_ack", 32'(inst_ack), 0);
        cyc(); m_gnt = 1'b1;
        @(negedge clk);
        check("c_hold", 32'({mem_req, data_done}), 32'b10);
        cyc(); m_gnt = 1'b0;
        @(negedge clk);
        check("c_data_done", 32'({data_done, inst_ack}), 32'b10);
        cyc();
        @(negedge clk);
        check("c_inst_ack", 32'(inst_ack), 1);
        cyc(); inst_req = 1'b0; m_gnt = 1'b1;
        cyc(); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1357_9BDF;
        cyc(); m_rvalid = 1'b0;
        @(negedge clk);
        check("c_inst_done", 32'(inst_done), 1);
        check("c_inst_rdata", inst_rdata, 32'h1357_9BDF);

        // Fetch flushed while waiting for read data.
        do_reset();
        inst_addr = 32'h30; inst_req = 1'b1;
        @(negedge clk);
        check("x_ack", 32'(inst_ack), 1);
        cyc(); inst_req = 1'b0; m_gnt = 1'b1;
        cyc(); m_gnt = 1'b0; inst_cancel = 1'b1;
        cyc(); inst_cancel = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1234_5678;
        cyc(); m_rvalid = 1'b0;
        @(negedge clk);
        check("x_resp_busy", 32'(busy), 1);
        check("x_no_done", 32'(inst_done), 0);
        cyc();
        @(negedge clk);
        check("x_idle", 32'({busy, inst_done}), 0);

        // Flush in idle blocks the fetch; data proceeds and ignores the flush.
        do_reset();
        inst_addr = 32'h40; inst_req = 1'b1; inst_cancel = 1'b1;
        data_addr = 32'h50; data_wen = 4'h0; data_req = 1'b1;
        @(negedge clk);
        check("k_acks", 32'({inst_ack, data_ack}), 32'b01);
        cyc(); inst_req = 1'b0; data_req = 1'b0; m_gnt = 1'b1;
        cyc(); m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0000_0055;
        cyc(); m_rvalid = 1'b0;
        @(negedge clk);
        check("k_data_done", 32'({data_done, inst_done}), 32'b10);
        check("k_data_rdata", data_rdata, 32'h55);
        inst_cancel = 1'b0;

        // Reset while issuing; a late read return must be ignored.
        do_reset();
        data_addr = 32'h60; data_wen = 4'h0; data_req = 1'b1;
        @(negedge clk);
        check("r_ack", 32'(data_ack), 1);
        cyc(); data_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("r_mem_req_low", 32'({mem_req, busy}), 0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        check("r_idle", 32'({mem_req, busy}), 0);
        cyc(); m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
        cyc(); m_rvalid = 1'b0;
        @(negedge clk);
        check("r_no_done", 32'({inst_done, data_done, busy}), 0);
        check("r_rdata_clear", data_rdata, 0);

        // Grant stalled for five cycles: request and fields stay put.
        do_reset();
        data_addr = 32'hABC0; data_wen = 4'h3; data_wdata = 32'hCAFE_F00D; data_req = 1'b1;
        @(negedge clk);
        check("s_ack", 32'(data_ack), 1);
        cyc(); data_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s_req", 32'(mem_req), 1);
            check("s_addr", mem_addr, 32'hABC0);
            check("s_wen", 32'(mem_wen), 32'h3);
            check("s_wdata", mem_wdata, 32'hCAFE_F00D);
            cyc();
        end
        m_gnt = 1'b1;
        cyc(); m_gnt = 1'b0;
        @(negedge clk);
        check("s_done", 32'(data_done), 1);

        // Randomized mixed traffic.
        do_reset();
        run_traffic(600, 1'b0);

        // Both masters saturating: four data grants, then one fetch, repeating.
        do_reset();
        run_traffic(80, 1'b1);
        if (grants.size() < 10) begin
            check("starve_grant_count", 32'(grants.size()), 10);
        end else begin
            for (int i = 0; i < 10; i++) begin
                check("starve_seq", 32'(grants[i]), 32'((i % 5) == 4));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
